// File: rtl/agu.sv
// Address generation unit for an in-place radix-2 DIT FFT.
// Turns (stage, butterfly index) into the two data-memory addresses of the
// butterfly and the twiddle-ROM index. All outputs are registered, one cycle
// of latency, no internal state other than the output registers.
module agu #(
    parameter int N = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [$clog2(N)-1:0]    i_stage,
    input  logic [$clog2(N)-2:0]    i_pair_id,
    output logic [$clog2(N)-1:0]    o_address1,
    output logic [$clog2(N)-1:0]    o_address2,
    output logic [$clog2(N)-1:0]    o_twiddle_address
);

    localparam int L = $clog2(N);
    localparam logic [L-1:0] LAST_STAGE = (L)'(L - 1);

    logic [L-1:0] w_s;
    logic [L-2:0] w_lowMask;
    logic [L-1:0] w_stageBit;
    logic [L-1:0] w_lo;
    logic [L-1:0] w_hi;
    logic [L-1:0] w_shamt;
    logic [L-1:0] w_address1;
    logic [L-1:0] w_address2;
    logic [L-1:0] w_twiddle;

    // Clamp the stage, then insert a bit at position s of pair_id by splitting
    // it into the bits below s (kept in place) and above s (moved up by one).
    always_comb begin
        w_s        = (i_stage > LAST_STAGE) ? LAST_STAGE : i_stage;
        w_lowMask  = '0;
        w_stageBit = '0;
        for (int i = 0; i < L - 1; i++) begin
            w_lowMask[i] = (i < int'(w_s));
        end
        for (int i = 0; i < L; i++) begin
            w_stageBit[i] = (i == int'(w_s));
        end
        w_lo       = {1'b0, i_pair_id & w_lowMask};
        w_hi       = {i_pair_id & ~w_lowMask, 1'b0};
        w_address1 = w_hi | w_lo;
        w_address2 = w_address1 | w_stageBit;
        w_shamt    = LAST_STAGE - w_s;
        w_twiddle  = w_lo << w_shamt;
    end

    // Output registers; synchronous reset clears everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_address1        <= '0;
            o_address2        <= '0;
            o_twiddle_address <= '0;
        end else begin
            o_address1        <= w_address1;
            o_address2        <= w_address2;
            o_twiddle_address <= w_twiddle;
        end
    end

endmodule

// File: tb/tb_agu.sv
// Self-checking bench for the FFT address generation unit (N=32).
// Expected values come from hand-computed vectors and from a plain-arithmetic
// reference model of the butterfly addressing rules.
module tb_agu;

    localparam int N = 32;
    localparam int L = 5;

    logic         clk;
    logic         rst;
    logic [L-1:0] stage;
    logic [L-2:0] pairId;
    logic [L-1:0] address1;
    logic [L-1:0] address2;
    logic [L-1:0] twiddle;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int stg;
        int pair;
        int a1;
        int a2;
        int tw;
    } vec_t;

    vec_t vecs[10];

    agu #(.N(N)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stage           (stage),
        .i_pair_id         (pairId),
        .o_address1        (address1),
        .o_address2        (address2),
        .o_twiddle_address (twiddle)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the even input of butterfly p at stage s sits in block p/2^s
    // of size 2^(s+1), at offset p mod 2^s; its partner is 2^s further on.
    function automatic void refModel(input int stg, input int pair,
                                     output int a1, output int a2, output int tw);
        int s;
        int span;
        s    = (stg > L - 1) ? L - 1 : stg;
        span = 2 ** s;
        a1   = (pair / span) * (2 * span) + (pair % span);
        a2   = a1 + span;
        tw   = (pair % span) * (2 ** (L - 1 - s));
    endfunction

    // Drive one request and step past the edge that samples it.
    task automatic applyStimulus(input int stg, input int pair, input logic r);
        stage  = stg[L-1:0];
        pairId = pair[L-2:0];
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int e1, input int e2, input int et);
        total++;
        if (int'(address1) != e1 || int'(address2) != e2 || int'(twiddle) != et) begin
            bad++;
            $display("[TB] FAIL %s: got a1=%0d a2=%0d tw=%0d, expected a1=%0d a2=%0d tw=%0d",
                     name, address1, address2, twiddle, e1, e2, et);
        end
    endtask

    initial begin
        int e1, e2, et;
        bit seen[N];
        int cnt;
        bit dup;

        vecs[0] = '{0,  5, 10, 11,  0};
        vecs[1] = '{1,  3,  5,  7,  8};
        vecs[2] = '{2,  5,  9, 13,  4};
        vecs[3] = '{4, 15, 15, 31, 15};
        vecs[4] = '{7, 15, 15, 31, 15};
        vecs[5] = '{3,  7,  7, 15, 14};
        vecs[6] = '{2,  0,  0,  4,  0};
        vecs[7] = '{0, 15, 30, 31,  0};
        vecs[8] = '{5,  9,  9, 25,  9};
        vecs[9] = '{3, 12, 20, 28,  8};

        rst    = 1'b1;
        stage  = '0;
        pairId = '0;
        @(posedge clk);
        #1;

        // Reset held for two cycles with arbitrary inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus($urandom_range(0, 31), $urandom_range(0, 15), 1'b1);
            checkOutput("reset", 0, 0, 0);
        end

        // Directed vectors.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stg, vecs[i].pair, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a2, vecs[i].tw);
        end

        // Back-to-back sweep of every stage; addresses must form a permutation.
        for (int s = 0; s < L; s++) begin
            foreach (seen[k]) seen[k] = 1'b0;
            dup = 1'b0;
            for (int p = 0; p < N / 2; p++) begin
                applyStimulus(s, p, 1'b0);
                refModel(s, p, e1, e2, et);
                checkOutput($sformatf("sweep s%0d p%0d", s, p), e1, e2, et);
                if (seen[address1] || seen[address2] || address1 == address2) dup = 1'b1;
                seen[address1] = 1'b1;
                seen[address2] = 1'b1;
            end
            cnt = 0;
            foreach (seen[k]) if (seen[k]) cnt++;
            total++;
            if (dup || cnt != N) begin
                bad++;
                $display("[TB] FAIL coverage s%0d: got %0d distinct (dup=%0d), expected %0d distinct",
                         s, cnt, dup, N);
            end
        end

        // Reset asserted in the middle of a sweep, then released.
        applyStimulus(2, 5, 1'b0);
        refModel(2, 5, e1, e2, et);
        checkOutput("midsweep pre", e1, e2, et);
        applyStimulus(2, 6, 1'b1);
        checkOutput("midsweep reset", 0, 0, 0);
        applyStimulus(2, 7, 1'b0);
        refModel(2, 7, e1, e2, et);
        checkOutput("midsweep resume", e1, e2, et);
        applyStimulus(3, 9, 1'b0);
        refModel(3, 9, e1, e2, et);
        checkOutput("midsweep next", e1, e2, et);

        // Random requests, including out-of-range stage codes.
        for (int i = 0; i < 300; i++) begin
            int rs, rp;
            rs = $urandom_range(0, 31);
            rp = $urandom_range(0, 15);
            applyStimulus(rs, rp, 1'b0);
            refModel(rs, rp, e1, e2, et);
            checkOutput($sformatf("rand s%0d p%0d", rs, rp), e1, e2, et);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
